// File: rtl/axis_mux_arbiter.sv
// Packet-atomic round-robin arbiter for a multi-source AXI-Stream mux.
// Holds a one-hot grant until the last beat handshakes on the master port, with a stall watchdog.
module axis_mux_arbiter #(
   parameter int NUM_SOURCES    = 2,
   parameter int TIMEOUT_WIDTH  = 8,
   parameter int TIMEOUT_CYCLES = 200,
   localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic [NUM_SOURCES-1:0] req,
   input  logic [NUM_SOURCES-1:0] suppress,
   input  logic                   m_tvalid,
   input  logic                   m_tready,
   input  logic                   m_tlast,
   output logic [NUM_SOURCES-1:0] grant,
   output logic [IDX_W-1:0]       grant_idx,
   output logic                   grant_valid,
   output logic                   timeout,
   output logic [15:0]            timeout_count
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_SOURCES - 1);
   localparam logic [IDX_W:0]           NUM_L    = (IDX_W + 1)'(NUM_SOURCES);
   localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                   r_state, w_state_next;
   logic [NUM_SOURCES-1:0]   r_grant, w_grant_next;
   logic [IDX_W-1:0]         r_grant_idx, w_grant_idx_next;
   logic                     r_grant_valid, w_grant_valid_next;
   logic [IDX_W-1:0]         r_ptr, w_ptr_next;
   logic [TIMEOUT_WIDTH-1:0] r_wd, w_wd_next;
   logic                     r_timeout, w_timeout_next;
   logic [15:0]              r_timeout_count, w_timeout_count_next;

   logic [NUM_SOURCES-1:0]   w_elig;
   logic [NUM_SOURCES-1:0]   w_rot;
   logic [NUM_SOURCES-1:0]   w_onehot;
   logic [2*NUM_SOURCES-1:0] w_dbl;
   logic [IDX_W-1:0]         w_off;
   logic [IDX_W:0]           w_sum;
   logic [IDX_W-1:0]         w_pick_idx;
   logic [IDX_W-1:0]         w_ptr_inc;
   logic                     w_any;
   logic                     w_pkt_end;
   logic                     w_wd_hit;

   assign w_elig = req & ~suppress;
   assign w_any  = |w_elig;

   // Rotate the eligible vector so the round-robin pointer lands on bit 0.
   assign w_dbl = {w_elig, w_elig} >> r_ptr;
   assign w_rot = w_dbl[NUM_SOURCES-1:0];

   always_comb begin
      w_off = '0;
      for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IDX_W'(k);
         end
      end
   end

   assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_pick_idx = (w_sum >= NUM_L) ? IDX_W'(w_sum - NUM_L) : w_sum[IDX_W-1:0];

   generate
      for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_onehot
         assign w_onehot[gi] = (w_pick_idx == IDX_W'(gi));
      end
   endgenerate

   assign w_ptr_inc = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + IDX_W'(1);
   assign w_pkt_end = m_tvalid & m_tready & m_tlast;
   assign w_wd_hit  = ~m_tvalid & (r_wd == WD_LAST);

   always_comb begin
      w_state_next         = r_state;
      w_grant_next         = r_grant;
      w_grant_idx_next     = r_grant_idx;
      w_grant_valid_next   = r_grant_valid;
      w_ptr_next           = r_ptr;
      w_wd_next            = r_wd;
      w_timeout_next       = 1'b0;
      w_timeout_count_next = r_timeout_count;
      case (r_state)
         ST_IDLE: begin
            w_wd_next = '0;
            if (w_any) begin
               w_grant_next       = w_onehot;
               w_grant_idx_next   = w_pick_idx;
               w_grant_valid_next = 1'b1;
               w_state_next       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_pkt_end || w_wd_hit) begin
               w_grant_next       = '0;
               w_grant_valid_next = 1'b0;
               w_ptr_next         = w_ptr_inc;
               w_wd_next          = '0;
               w_state_next       = ST_IDLE;
               // A real packet end on the same cycle as the watchdog expiry is not a stall.
               if (!w_pkt_end) begin
                  w_timeout_next = 1'b1;
                  if (r_timeout_count != 16'hFFFF) begin
                     w_timeout_count_next = r_timeout_count + 16'd1;
                  end
               end
            end else if (m_tvalid) begin
               w_wd_next = '0;
            end else begin
               w_wd_next = r_wd + TIMEOUT_WIDTH'(1);
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state         <= ST_IDLE;
         r_grant         <= '0;
         r_grant_idx     <= '0;
         r_grant_valid   <= 1'b0;
         r_ptr           <= '0;
         r_wd            <= '0;
         r_timeout       <= 1'b0;
         r_timeout_count <= '0;
      end else begin
         r_state         <= w_state_next;
         r_grant         <= w_grant_next;
         r_grant_idx     <= w_grant_idx_next;
         r_grant_valid   <= w_grant_valid_next;
         r_ptr           <= w_ptr_next;
         r_wd            <= w_wd_next;
         r_timeout       <= w_timeout_next;
         r_timeout_count <= w_timeout_count_next;
      end
   end

   assign grant         = r_grant;
   assign grant_idx     = r_grant_idx;
   assign grant_valid   = r_grant_valid;
   assign timeout       = r_timeout;
   assign timeout_count = r_timeout_count;

endmodule

// File: doc/axis_mux_arbiter.md
Name: axis_mux_arbiter

Overview:
Packet-atomic round-robin arbiter that sequences the output side of the multi-source AXI-Stream mux in the FOFB read-links path. It watches per-source "packet available" requests from the source FIFOs and honours per-source arbitration suppress inputs. It issues a one-hot grant that is held until the granted packet's last beat handshakes on the master port. A watchdog releases a grant if the granted source stalls mid-packet.

Parameters:
NUM_SOURCES, 2, number of requesters (2..16)
TIMEOUT_WIDTH, 8, width of the stall watchdog counter
TIMEOUT_CYCLES, 200, consecutive cycles with no tvalid on the granted source before forced release (must be < 2**TIMEOUT_WIDTH)

Ports:
clk  in  1  single clock, master-side mux clock
arst  in  1  asynchronous reset, active-high
req  in  NUM_SOURCES  source FIFO holds at least one full packet
suppress  in  NUM_SOURCES  1 = source excluded from new arbitration (ARB_REQ_SUPPRESS)
m_tvalid  in  1  mux output tvalid, observed
m_tready  in  1  mux output tready, observed
m_tlast  in  1  mux output tlast, observed
grant  out  NUM_SOURCES  one-hot select to mux datapath
grant_idx  out  clog2(NUM_SOURCES)  binary index of grant
grant_valid  out  1  a grant is active
timeout  out  1  one-cycle pulse on forced release
timeout_count  out  16  saturating count of forced releases

Behaviour:
- Reset (async assert, sync deassert handled upstream): grant=0, grant_idx=0, grant_valid=0, timeout=0, timeout_count=0, state=IDLE, rr pointer=0 (source 0 has highest priority first), watchdog=0.
- Eligible vector: elig = req & ~suppress.
- State IDLE: if elig != 0, choose the first set bit at or after rr pointer, wrapping modulo NUM_SOURCES. Register grant, grant_idx and grant_valid=1, then go to BUSY. Grant is visible 1 cycle after elig is sampled. Elig == 0: stay in IDLE, outputs unchanged (grant=0).
- State BUSY:
  - Packet end: m_tvalid & m_tready & m_tlast. Same clock edge: grant=0, grant_valid=0, rr pointer=(grant_idx+1) mod NUM_SOURCES, state=IDLE.
  - No back-to-back grant in the end cycle: minimum 1 idle cycle between packets. Re-arbitration happens in the next IDLE cycle.
  - Suppress or req deassertion while BUSY does not revoke the grant (packet atomicity).
- Watchdog (BUSY only): clears on any cycle with m_tvalid=1, otherwise increments.
  - On reaching TIMEOUT_CYCLES: release exactly as at packet end (pointer advances past the stalled source), pulse timeout for 1 cycle, increment timeout_count, which saturates at 0xFFFF.
  - Watchdog clears on entering IDLE.
  - If packet end and timeout occur in the same cycle, packet end wins: no timeout pulse, no count.
- m_tready=0 with m_tvalid=1 counts as activity (backpressure never triggers timeout).
- Single-requester case: the same source can be regranted every 2 cycles (grant, end, idle, grant).
- Reset asserted mid-packet: immediate return to reset values. The datapath is expected to flush its FIFOs on the same reset.
- grant is always one-hot or zero. grant_idx is held at its last value while grant_valid=0.

Test Plan:
- Reset then req=2'b11, suppress=0, single-beat packets (tlast every beat, tready=1) -> grant sequence 01,10,01,10, each grant 1 cycle wide, 1 idle cycle between grants.
- req=2'b11, suppress=2'b01 -> only source 1 granted. Release suppress mid-packet of source 1 -> next grant goes to source 0.
- Source 1 granted, 4-beat packet with tready toggling 1/0 -> grant held for all 4 handshakes and released on the cycle of the tlast handshake; no timeout.
- Source 0 granted, m_tvalid held 0 for 200 cycles -> timeout pulse at cycle 200, timeout_count=1, next grant goes to source 1 if it is requesting.
- Packet-end handshake on exactly watchdog cycle 200 -> normal release, timeout=0, timeout_count unchanged.
- NUM_SOURCES=4, req=4'b1010, rr pointer=3 -> grant source 3, then source 1 (wrap), then source 3.
